vga_sync_gen: RTL and testbench

Timing generator that drives the VGA connector and feeds pixel coordinates to the graphics/animation logic. Divides the system clock into a pixel-rate enable and runs horizontal and vertical scan counters. From those counters it produces hsync, vsync, video_on, pix_x, pix_y and a once-per-frame tick. Default timing is 640x480 at 60 Hz from a 50 MHz clk, giving 800 x 525 total pixel periods per frame.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/pixel_tick_gen.sv | 55 +++++
 rtl/vga_sync_gen.sv | 100 ++++++++++
 tb/tb_vga_sync_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// vga_timing_pkg : default VGA timing constants and coordinate type
// Rev 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  localparam int H_DISP_DEF = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_DISP_DEF = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOT_DEF = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOT_DEF = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [COORD_W-1:0] coord_t;

  // True when v lies in the inclusive window lo .. lo+len-1.
  function automatic logic in_window(input coord_t v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_tick_gen.sv
`default_nettype none
// ============================================================================
// pixel_tick_gen : divides clk into a one-cycle pixel-rate enable
// Rev 1.0 - initial release
// ============================================================================
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("pixel_tick_gen: CLK_DIV must be in 1..16");
  end

  if (CLK_DIV == 1) begin : g_div1
    logic p_tick_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) p_tick_q <= 1'b0;
      else        p_tick_q <= 1'b1;
    end

    assign p_tick = p_tick_q;
  end else begin : g_divn
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             p_tick_q, p_tick_d;

    // The tick is registered off the terminal count, so it lands on the
    // CLK_DIV-th edge after reset release.
    always_comb begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      p_tick_d = (div_q == DIV_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        div_q    <= '0;
        p_tick_q <= 1'b0;
      end else begin
        div_q    <= div_d;
        p_tick_q <= p_tick_d;
      end
    end

    assign p_tick = p_tick_q;
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// vga_sync_gen : VGA scan counters, sync pulses, video_on and frame tick
// Rev 1.0 - initial release
// ============================================================================
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_DISP   = H_DISP_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_DISP   = V_DISP_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SYNC_POL = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic               frame_tick,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y
);

  localparam int     H_TOT    = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int     V_TOT    = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int     HS_START = H_DISP + H_FP;
  localparam int     VS_START = V_DISP + V_FP;
  localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam logic   SYNC_ACT = (SYNC_POL != 0);

  if (H_TOT > COORD_MAX) begin : g_bad_htot
    $error("vga_sync_gen: H_TOT exceeds coordinate range");
  end
  if (V_TOT > COORD_MAX) begin : g_bad_vtot
    $error("vga_sync_gen: V_TOT exceeds coordinate range");
  end

  logic   tick;
  coord_t pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic   hsync_q, hsync_d, vsync_q, vsync_d;
  logic   frame_tick_q, frame_tick_d;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  // Syncs decode the next-state counts so the registered pulses line up
  // with the registered coordinates.
  always_comb begin
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    if (tick) begin
      if (pix_x_q == H_LAST) begin
        pix_x_d = '0;
        pix_y_d = (pix_y_q == V_LAST) ? '0 : pix_y_q + coord_t'(1);
      end else begin
        pix_x_d = pix_x_q + coord_t'(1);
      end
    end
    frame_tick_d = tick && (pix_x_q == H_LAST) && (pix_y_q == V_LAST);
    hsync_d      = in_window(pix_x_d, HS_START, H_SYNC) ? SYNC_ACT : ~SYNC_ACT;
    vsync_d      = in_window(pix_y_d, VS_START, V_SYNC) ? SYNC_ACT : ~SYNC_ACT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      hsync_q      <= ~SYNC_ACT;
      vsync_q      <= ~SYNC_ACT;
      frame_tick_q <= 1'b0;
    end else begin
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;
  assign p_tick     = tick;
  assign video_on   = (int'(pix_x_q) < H_DISP) && (int'(pix_y_q) < V_DISP);

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_sync_gen : scoreboard bench for vga_sync_gen (default + small timings)
// Rev 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

  logic clk, reset;

  // A: default 800x525 timing, CLK_DIV=2. B: 20x12 timing, CLK_DIV=2.
  // C: 20x12 timing, CLK_DIV=1, active-high syncs.
  logic       a_hs, a_vs, a_von, a_pt, a_ft;
  logic [9:0] a_x, a_y;
  logic       b_hs, b_vs, b_von, b_pt, b_ft;
  logic [9:0] b_x, b_y;
  logic       c_hs, c_vs, c_von, c_pt, c_ft;
  logic [9:0] c_x, c_y;

  vga_sync_gen u_a (
    .clk(clk), .reset(reset), .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
    .p_tick(a_pt), .frame_tick(a_ft), .pix_x(a_x), .pix_y(a_y)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_DISP(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(0)
  ) u_b (
    .clk(clk), .reset(reset), .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
    .p_tick(b_pt), .frame_tick(b_ft), .pix_x(b_x), .pix_y(b_y)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISP(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
    .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1)
  ) u_c (
    .clk(clk), .reset(reset), .hsync(c_hs), .vsync(c_vs), .video_on(c_von),
    .p_tick(c_pt), .frame_tick(c_ft), .pix_x(c_x), .pix_y(c_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising edges since the latest reset release.
  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // t < 0 : check while reset is held; otherwise check after edge t.
  typedef struct {
    int          dut;
    int          t;
    logic [24:0] exp;
  } vec_t;

  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   phase = 0;
  bit   final_req = 1'b0;

  task automatic push(input int d, input int t, input int x, input int y,
                      input bit hs, input bit vs, input bit von, input bit pt, input bit ft);
    vec_t v;
    v.dut = d;
    v.t   = t;
    v.exp = {10'(x), 10'(y), hs, vs, von, pt, ft};
    sb.push_back(v);
  endtask

  function automatic logic [24:0] obs(input int d);
    case (d)
      0:       return {a_x, a_y, a_hs, a_vs, a_von, a_pt, a_ft};
      1:       return {b_x, b_y, b_hs, b_vs, b_von, b_pt, b_ft};
      default: return {c_x, c_y, c_hs, c_vs, c_von, c_pt, c_ft};
    endcase
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, need %0d", nm, got, exp);
    end
  endtask

  task automatic vchk(input vec_t v);
    logic [24:0] g;
    g = obs(v.dut);
    n_vec++;
    if (g !== v.exp) begin
      n_err++;
      $display("FAIL vec dut%0d t=%0d: got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b, need x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b",
               v.dut, v.t, g[24:15], g[14:5], g[4], g[3], g[2], g[1], g[0],
               v.exp[24:15], v.exp[14:5], v.exp[4], v.exp[3], v.exp[2], v.exp[1], v.exp[0]);
    end
  endtask

  // Monitor: pops scoreboard entries as the DUTs reach them, plus window counts.
  initial begin : monitor
    int a_pt_n, a_hs_low, b_vs_low, b_ft_n, c_ft_n, last_b, last_c;
    a_pt_n = 0; a_hs_low = 0; b_vs_low = 0; b_ft_n = 0; c_ft_n = 0;
    last_b = -1; last_c = -1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_b = -1;
        last_c = -1;
      end else if (phase == 1) begin
        if (a_pt && cyc <= 1600) a_pt_n++;
        if (a_pt && a_y == 10'd0 && !a_hs) a_hs_low++;
        if (b_pt && !b_vs && cyc <= 480) b_vs_low++;
        if (b_ft) begin
          if (last_b >= 0) chk("b_frame_period", cyc - last_b, 480);
          last_b = cyc;
          b_ft_n++;
        end
        if (c_ft) begin
          if (last_c >= 0) chk("c_frame_period", cyc - last_c, 240);
          last_c = cyc;
          c_ft_n++;
        end
        if (cyc == 1700) begin
          chk("a_ptick_per_line", a_pt_n, 800);
          chk("a_hsync_low_pixels", a_hs_low, 96);
          chk("b_vsync_low_pixels", b_vs_low, 40);
          chk("b_frame_ticks", b_ft_n, 3);
          chk("c_frame_ticks", c_ft_n, 7);
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if ((reset && sb[i].t == cyc) || (!reset && sb[i].t < 0)) begin
          vchk(sb[i]);
          sb.delete(i);
        end
      end
      if (final_req) begin
        foreach (sb[i]) begin
          n_vec++;
          n_err++;
          $display("FAIL vec dut%0d t=%0d: never reached, need checkpoint", sb[i].dut, sb[i].t);
        end
        sb.delete();
        final_req = 1'b0;
      end
    end
  end

  task automatic push_reset_vecs();
    push(0, -1, 0, 0, 1, 1, 1, 0, 0);
    push(1, -1, 0, 0, 1, 1, 1, 0, 0);
    push(2, -1, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin : stim
    int n;
    reset = 1'b1;
    push_reset_vecs();
    #1 reset = 1'b0;

    // dut, t, x, y, hs, vs, von, pt, ft
    push(0,    1,   0, 0, 1, 1, 1, 0, 0);
    push(0,    2,   0, 0, 1, 1, 1, 1, 0);
    push(0,    3,   1, 0, 1, 1, 1, 0, 0);
    push(0,    4,   1, 0, 1, 1, 1, 1, 0);
    push(0, 1280, 639, 0, 1, 1, 1, 1, 0);
    push(0, 1282, 640, 0, 1, 1, 0, 1, 0);
    push(0, 1312, 655, 0, 1, 1, 0, 1, 0);
    push(0, 1314, 656, 0, 0, 1, 0, 1, 0);
    push(0, 1504, 751, 0, 0, 1, 0, 1, 0);
    push(0, 1506, 752, 0, 1, 1, 0, 1, 0);
    push(0, 1600, 799, 0, 1, 1, 0, 1, 0);
    push(0, 1601,   0, 1, 1, 1, 1, 0, 0);
    push(0, 1602,   0, 1, 1, 1, 1, 1, 0);

    push(1,   1,  0,  0, 1, 1, 1, 0, 0);
    push(1,   2,  0,  0, 1, 1, 1, 1, 0);
    push(1,  22, 10,  0, 1, 1, 0, 1, 0);
    push(1,  24, 11,  0, 1, 1, 0, 1, 0);
    push(1,  26, 12,  0, 0, 1, 0, 1, 0);
    push(1,  30, 14,  0, 0, 1, 0, 1, 0);
    push(1,  32, 15,  0, 1, 1, 0, 1, 0);
    push(1, 220,  9,  5, 1, 1, 1, 1, 0);
    push(1, 242,  0,  6, 1, 1, 0, 1, 0);
    push(1, 280, 19,  6, 1, 1, 0, 1, 0);
    push(1, 282,  0,  7, 1, 0, 0, 1, 0);
    push(1, 360, 19,  8, 1, 0, 0, 1, 0);
    push(1, 362,  0,  9, 1, 1, 0, 1, 0);
    push(1, 480, 19, 11, 1, 1, 0, 1, 0);
    push(1, 481,  0,  0, 1, 1, 1, 0, 1);
    push(1, 482,  0,  0, 1, 1, 1, 1, 0);
    push(1, 961,  0,  0, 1, 1, 1, 0, 1);

    push(2,   1,  0,  0, 0, 0, 1, 1, 0);
    push(2,   2,  1,  0, 0, 0, 1, 1, 0);
    push(2,  12, 11,  0, 0, 0, 0, 1, 0);
    push(2,  13, 12,  0, 1, 0, 0, 1, 0);
    push(2,  15, 14,  0, 1, 0, 0, 1, 0);
    push(2,  16, 15,  0, 0, 0, 0, 1, 0);
    push(2, 140, 19,  6, 0, 0, 0, 1, 0);
    push(2, 141,  0,  7, 0, 1, 0, 1, 0);
    push(2, 240, 19, 11, 0, 0, 0, 1, 0);
    push(2, 241,  0,  0, 0, 0, 1, 1, 1);
    push(2, 242,  1,  0, 0, 0, 1, 1, 0);

    phase = 1;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    repeat (1710) @(negedge clk);
    phase = 2;

    n = 0;
    while (!(b_x == 10'd7 && b_y == 10'd5) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      $display("FAIL wait_b_7_5: got x=%0d y=%0d, need x=7 y=5 within 1000 clk", b_x, b_y);
      $fatal(1, "scan position never reached");
    end

    // Reset lands between edges; the next negedge sees it before any posedge.
    @(posedge clk);
    #2 reset = 1'b0;
    push_reset_vecs();
    repeat (3) @(posedge clk);
    #2;
    push(0,  1,  0, 0, 1, 1, 1, 0, 0);
    push(0,  2,  0, 0, 1, 1, 1, 1, 0);
    push(0,  3,  1, 0, 1, 1, 1, 0, 0);
    push(1,  1,  0, 0, 1, 1, 1, 0, 0);
    push(1,  2,  0, 0, 1, 1, 1, 1, 0);
    push(1,  3,  1, 0, 1, 1, 1, 0, 0);
    push(2,  1,  0, 0, 0, 0, 1, 1, 0);
    push(2,  2,  1, 0, 0, 0, 1, 1, 0);
    push(2, 20, 19, 0, 0, 0, 0, 1, 0);
    push(2, 21,  0, 1, 0, 0, 1, 1, 0);
    reset = 1'b1;
    repeat (60) @(negedge clk);

    final_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
